// File: rtl/iq_block_quantizer_pkg.sv
// Shared fronthaul IQ parameters and types.
//   Widths of the raw and quantised IQ components, block length, exponent
//   width, packed I/Q sample types, the ping-pong bank state, and the
//   per-component helpers (saturating magnitude, round-and-saturate).
package iq_block_quantizer_pkg;

  localparam int QUANTISATION_BITWIDTH = 8;
  localparam int INPUT_SAMPLE_BITWIDTH = 16;
  localparam int BLOCK_LEN             = 12;
  localparam int EXPONENT_BITWIDTH     = 4;

  // Wide enough to hold BLOCK_LEN itself (bank length of a full block).
  localparam int BLK_CNT_W = $clog2(BLOCK_LEN + 1);

  // Largest symmetric quantised magnitude, in the rounding datapath width.
  localparam logic signed [INPUT_SAMPLE_BITWIDTH:0] Q_MAX =
    (INPUT_SAMPLE_BITWIDTH + 1)'(2 ** (QUANTISATION_BITWIDTH - 1) - 1);

  typedef struct packed {
    logic signed [INPUT_SAMPLE_BITWIDTH-1:0] i;
    logic signed [INPUT_SAMPLE_BITWIDTH-1:0] q;
  } iq_in_t;

  typedef struct packed {
    logic signed [QUANTISATION_BITWIDTH-1:0] i;
    logic signed [QUANTISATION_BITWIDTH-1:0] q;
  } iq_q_t;

  typedef enum logic [1:0] {FREE, FILLING, CLOSED, DRAINING} bank_state_t;

  // |x| with the most negative code folded onto the most positive one, so
  // the result always fits the signed input range.
  function automatic logic [INPUT_SAMPLE_BITWIDTH-1:0] sat_abs(
    input logic signed [INPUT_SAMPLE_BITWIDTH-1:0] x
  );
    logic [INPUT_SAMPLE_BITWIDTH-1:0] r;
    if (x == {1'b1, {(INPUT_SAMPLE_BITWIDTH-1){1'b0}}}) r = {1'b0, {(INPUT_SAMPLE_BITWIDTH-1){1'b1}}};
    else if (x[INPUT_SAMPLE_BITWIDTH-1])               r = -x;
    else                                                r = x;
    return r;
  endfunction

  // Round half up, arithmetic shift by e, clamp to the symmetric range.
  // One guard bit keeps x + 2^(e-1) from overflowing.
  function automatic logic signed [QUANTISATION_BITWIDTH-1:0] quantise(
    input logic signed [INPUT_SAMPLE_BITWIDTH-1:0] x,
    input logic        [EXPONENT_BITWIDTH-1:0]     e
  );
    logic signed [INPUT_SAMPLE_BITWIDTH:0] rnd;
    logic signed [INPUT_SAMPLE_BITWIDTH:0] sum;
    logic signed [INPUT_SAMPLE_BITWIDTH:0] sh;
    logic signed [QUANTISATION_BITWIDTH-1:0] r;
    rnd = '0;
    if (e != '0) rnd = {{INPUT_SAMPLE_BITWIDTH{1'b0}}, 1'b1} << (e - 1'b1);
    sum = {x[INPUT_SAMPLE_BITWIDTH-1], x} + rnd;
    sh  = sum >>> e;
    if (sh > Q_MAX)       r = Q_MAX[QUANTISATION_BITWIDTH-1:0];
    else if (sh < -Q_MAX) r = -Q_MAX[QUANTISATION_BITWIDTH-1:0];
    else                  r = sh[QUANTISATION_BITWIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/iq_block_quantizer_exp.sv
// bfp_exponent_calc: block maximum magnitude -> shared right-shift exponent.
//   run_max  : largest saturated magnitude seen in the block (unsigned)
//   exponent : smallest e in 0..IN_W-Q_W with (run_max >> e) < 2^(Q_W-1)
// Purely combinational; shared with the decompressor side.
module bfp_exponent_calc #(
  parameter int IN_W  = 16,
  parameter int Q_W   = 8,
  parameter int EXP_W = 4
) (
  input  logic [IN_W-1:0]  run_max,
  output logic [EXP_W-1:0] exponent
);

  int msb_pos;
  int e_int;

  // With the leading one at position p the shifted value fits Q_W-1 bits
  // once e >= p - Q_W + 2; clamp into the legal exponent range.
  always_comb begin
    msb_pos = -1;
    for (int b = 0; b < IN_W; b++) begin
      if (run_max[b]) msb_pos = b;
    end
    e_int = msb_pos - Q_W + 2;
    if (e_int < 0)           e_int = 0;
    if (e_int > IN_W - Q_W)  e_int = IN_W - Q_W;
    exponent = EXP_W'(e_int);
  end

endmodule

// File: rtl/iq_block_quantizer.sv
// iq_block_quantizer: block-floating-point IQ compressor.
//   clk, rst          : clock, synchronous active-high reset
//   syncTo10ms        : frame strobe, rising edge closes any partial block
//   inData/inValid/inReady : I (upper) / Q (lower) samples, valid/ready
//   quantizedData/outValid/outReady : requantised I/Q, valid/ready
//   blockExponent     : right shift applied to the current block
//   outFirst/outLast  : first / last sample of a block
// Two ping-pong banks: one fills while the other drains into a single
// registered output stage.
module iq_block_quantizer
  import iq_block_quantizer_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 syncTo10ms,
  input  logic [2*INPUT_SAMPLE_BITWIDTH-1:0]   inData,
  input  logic                                 inValid,
  output logic                                 inReady,
  output logic [2*QUANTISATION_BITWIDTH-1:0]   quantizedData,
  output logic                                 outValid,
  input  logic                                 outReady,
  output logic [EXPONENT_BITWIDTH-1:0]         blockExponent,
  output logic                                 outFirst,
  output logic                                 outLast
);

  localparam int IN_W  = INPUT_SAMPLE_BITWIDTH;
  localparam int EXP_W = EXPONENT_BITWIDTH;
  localparam int CNT_W = BLK_CNT_W;

  // ---------------- state ----------------
  logic              sync_d_q,  sync_d_d;
  logic              wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]  wr_cnt_q,  wr_cnt_d;
  logic [IN_W-1:0]   run_max_q, run_max_d;

  bank_state_t       bank_state_q [2];
  bank_state_t       bank_state_d [2];
  logic [CNT_W-1:0]  bank_len_q   [2];
  logic [CNT_W-1:0]  bank_len_d   [2];
  logic [EXP_W-1:0]  bank_exp_q   [2];
  logic [EXP_W-1:0]  bank_exp_d   [2];
  iq_in_t            mem_q        [2][BLOCK_LEN];
  iq_in_t            mem_d        [2][BLOCK_LEN];

  logic              rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  rd_cnt_q,  rd_cnt_d;

  logic              out_valid_q, out_valid_d;
  iq_q_t             out_data_q,  out_data_d;
  logic [EXP_W-1:0]  out_exp_q,   out_exp_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q,  out_last_d;

  // ---------------- decode ----------------
  iq_in_t            in_s;
  logic [IN_W-1:0]   abs_i, abs_q, samp_max, acc_max, close_max;
  logic [EXP_W-1:0]  close_exp;
  logic [CNT_W-1:0]  close_len;
  logic              sync_edge, wr_open, accept;
  logic              close_full, close_sync, close_any;
  logic              rd_avail, load, rd_first, rd_last;
  iq_in_t            rd_samp;
  logic [EXP_W-1:0]  rd_exp;

  always_comb begin
    in_s      = iq_in_t'(inData);
    abs_i     = sat_abs(in_s.i);
    abs_q     = sat_abs(in_s.q);
    samp_max  = (abs_i > abs_q) ? abs_i : abs_q;
    acc_max   = (samp_max > run_max_q) ? samp_max : run_max_q;

    sync_edge = syncTo10ms && !sync_d_q;
    wr_open   = (bank_state_q[wr_bank_q] == FREE) || (bank_state_q[wr_bank_q] == FILLING);
    inReady   = !rst && wr_open && !sync_edge;
    accept    = inValid && inReady;

    close_full = accept && (wr_cnt_q == CNT_W'(BLOCK_LEN - 1));
    close_sync = sync_edge && (wr_cnt_q != '0);
    close_any  = close_full || close_sync;
    // A full-block close must include the sample landing this cycle.
    close_max  = close_full ? acc_max : run_max_q;
    close_len  = close_full ? CNT_W'(BLOCK_LEN) : wr_cnt_q;

    rd_avail = (bank_state_q[rd_bank_q] == CLOSED) || (bank_state_q[rd_bank_q] == DRAINING);
    load     = rd_avail && (!out_valid_q || outReady);
    rd_samp  = mem_q[rd_bank_q][rd_cnt_q];
    rd_exp   = bank_exp_q[rd_bank_q];
    rd_first = (rd_cnt_q == '0);
    rd_last  = (rd_cnt_q == bank_len_q[rd_bank_q] - 1'b1);
  end

  // Exponent is derived in the closing cycle so it lands in the bank
  // together with the CLOSED state.
  bfp_exponent_calc #(
    .IN_W  (IN_W),
    .Q_W   (QUANTISATION_BITWIDTH),
    .EXP_W (EXP_W)
  ) u_exp (
    .run_max  (close_max),
    .exponent (close_exp)
  );

  // ---------------- next state ----------------
  always_comb begin
    sync_d_d     = syncTo10ms;
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = wr_cnt_q;
    run_max_d    = run_max_q;
    bank_state_d = bank_state_q;
    bank_len_d   = bank_len_q;
    bank_exp_d   = bank_exp_q;
    mem_d        = mem_q;
    rd_bank_d    = rd_bank_q;
    rd_cnt_d     = rd_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_exp_d    = out_exp_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;

    // Write side
    if (accept) begin
      mem_d[wr_bank_q][wr_cnt_q] = in_s;
      wr_cnt_d  = wr_cnt_q + 1'b1;
      run_max_d = acc_max;
      if (bank_state_q[wr_bank_q] == FREE) bank_state_d[wr_bank_q] = FILLING;
    end
    if (close_any) begin
      bank_state_d[wr_bank_q] = CLOSED;
      bank_len_d[wr_bank_q]   = close_len;
      bank_exp_d[wr_bank_q]   = close_exp;
      wr_cnt_d                = '0;
      run_max_d               = '0;
      wr_bank_d               = !wr_bank_q;
    end

    // Read side. The bank is released as soon as its last sample has moved
    // into the output register: that copy no longer needs the storage, and
    // releasing here lets the writer reuse the bank without a bubble.
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d.i = quantise(rd_samp.i, rd_exp);
      out_data_d.q = quantise(rd_samp.q, rd_exp);
      out_exp_d    = rd_exp;
      out_first_d  = rd_first;
      out_last_d   = rd_last;
      if (rd_first) bank_state_d[rd_bank_q] = DRAINING;
      if (rd_last) begin
        bank_state_d[rd_bank_q] = FREE;
        rd_cnt_d                = '0;
        rd_bank_d               = !rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d_q    <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      run_max_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_exp_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_state_q[b] <= FREE;
        bank_len_q[b]   <= '0;
        bank_exp_q[b]   <= '0;
      end
    end else begin
      sync_d_q     <= sync_d_d;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      run_max_q    <= run_max_d;
      rd_bank_q    <= rd_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_exp_q    <= out_exp_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      bank_state_q <= bank_state_d;
      bank_len_q   <= bank_len_d;
      bank_exp_q   <= bank_exp_d;
    end
  end

  // Sample storage needs no reset; bank state decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign quantizedData = out_data_q;
  assign outValid      = out_valid_q;
  assign blockExponent = out_exp_q;
  assign outFirst      = out_first_q;
  assign outLast       = out_last_q;

endmodule

// File: tb/tb_iq_block_quantizer.sv
module tb_iq_block_quantizer;
  import iq_block_quantizer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        syncTo10ms = 1'b0;
  logic [31:0] inData = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] quantizedData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [3:0]  blockExponent;
  logic        outFirst, outLast;

  iq_block_quantizer dut (
    .clk(clk), .rst(rst), .syncTo10ms(syncTo10ms),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .quantizedData(quantizedData), .outValid(outValid), .outReady(outReady),
    .blockExponent(blockExponent), .outFirst(outFirst), .outLast(outLast)
  );

  always #5 clk = ~clk;

  typedef struct { int i; int q; int e; bit first; bit last; int cyc; } rec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_count = 0;
  bit          sync_prev = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [31:0] blk[$];
  logic [31:0] stim[$];
  rec_t        exp_q[$];
  rec_t        act_q[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) outReady = ($urandom_range(99) < 60);
  end

  function automatic logic [31:0] mk(input int i, input int q);
    logic [31:0] r;
    r = {i[15:0], q[15:0]};
    return r;
  endfunction

  function automatic int rnd_val();
    int amp, v;
    amp = $urandom_range(15);
    v = int'($urandom_range(2 * (1 << amp))) - (1 << amp);
    if ($urandom_range(19) == 0) v = -32768;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Reference: ideal round-half-up division by 2^e, then symmetric clamp.
  function automatic int q_ref(input int x, input int e);
    int d, v, r;
    d = 1 << e;
    v = x + ((e > 0) ? d / 2 : 0);
    if (v >= 0) r = v / d;
    else        r = -((-v + d - 1) / d);
    if (r > 127)  r = 127;
    if (r < -127) r = -127;
    return r;
  endfunction

  function automatic void model_close_block();
    int m, e, ii, qq, a;
    rec_t r;
    m = 0;
    foreach (blk[k]) begin
      ii = int'($signed(blk[k][31:16]));
      qq = int'($signed(blk[k][15:0]));
      a = (ii < 0) ? -ii : ii; if (a > 32767) a = 32767; if (a > m) m = a;
      a = (qq < 0) ? -qq : qq; if (a > 32767) a = 32767; if (a > m) m = a;
    end
    e = 0;
    while (e < 8 && (m >> e) >= 128) e++;
    foreach (blk[k]) begin
      r.i = q_ref(int'($signed(blk[k][31:16])), e);
      r.q = q_ref(int'($signed(blk[k][15:0])), e);
      r.e = e;
      r.first = (k == 0);
      r.last = (k == blk.size() - 1);
      r.cyc = cyc;
      exp_q.push_back(r);
    end
    blk.delete();
  endfunction

  // Observes handshakes away from the active edge and feeds the model.
  always @(negedge clk) begin
    rec_t r;
    if (rst) begin
      blk.delete();
      sync_prev = 1'b0;
    end else begin
      if (syncTo10ms && !sync_prev && blk.size() > 0) model_close_block();
      sync_prev = syncTo10ms;
      if (inValid && inReady) begin
        blk.push_back(inData);
        acc_count++;
        if (blk.size() == BLOCK_LEN) model_close_block();
      end
      if (outValid && outReady) begin
        r.i = int'($signed(quantizedData[15:8]));
        r.q = int'($signed(quantizedData[7:0]));
        r.e = int'(blockExponent);
        r.first = outFirst;
        r.last = outLast;
        r.cyc = cyc;
        act_q.push_back(r);
      end
    end
  end

  task automatic drive_stim(input int gap_pct, output bit ok);
    bit acc;
    int waited;
    ok = 1'b1;
    for (int k = 0; k < stim.size(); k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        inValid = 1'b0;
        @(posedge clk); #1;
      end
      inValid = 1'b1;
      inData = stim[k];
      waited = 0;
      acc = 1'b0;
      while (!acc && waited < 300) begin
        @(negedge clk); acc = inReady;
        @(posedge clk); #1;
        waited++;
      end
      if (!acc) ok = 1'b0;
    end
    inValid = 1'b0;
    stim.delete();
  endtask

  task automatic wait_drain(output bit ok);
    int t;
    t = 0;
    while ((act_q.size() < exp_q.size() || blk.size() > 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) begin @(posedge clk); #1; end
    ok = (t < 3000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || quantizedData !== 16'h0 || blockExponent !== 4'h0 ||
        outFirst !== 1'b0 || outLast !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%0d f=%b l=%b, expected all 0",
               outValid, quantizedData, blockExponent, outFirst, outLast);
    end
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("FAIL reset_inready_low: got %b expected 0", inReady); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inready_release: got %b expected 1", inReady); end
    @(posedge clk); #1;
  endtask

  task automatic test_constant_block();
    bit ok;
    outReady = 1'b1;
    repeat (12) stim.push_back(mk(100, -50));
    drive_stim(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t1_input_stall: got stall, expected 12 accepts"); end
    wait_drain(ok);
    checks++;
    if (!ok || act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t1_count: got %0d outputs expected %0d", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      checks++;
      if (act_q[k].i !== exp_q[k].i || act_q[k].q !== exp_q[k].q || act_q[k].e !== exp_q[k].e ||
          act_q[k].first !== exp_q[k].first || act_q[k].last !== exp_q[k].last) begin
        errors++;
        $display("FAIL t1_sample%0d: got i=%0d q=%0d e=%0d f=%b l=%b expected i=%0d q=%0d e=%0d f=%b l=%b",
                 k, act_q[k].i, act_q[k].q, act_q[k].e, act_q[k].first, act_q[k].last,
                 exp_q[k].i, exp_q[k].q, exp_q[k].e, exp_q[k].first, exp_q[k].last);
      end
    end
    if (act_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (act_q[0].i !== 100 || act_q[0].q !== -50) begin
        errors++; $display("FAIL t1_value: got i=%0d q=%0d expected 100 -50", act_q[0].i, act_q[0].q);
      end
      checks++;
      if (act_q[0].cyc - exp_q[0].cyc !== 2) begin
        errors++; $display("FAIL t1_latency: got %0d cycles expected 2", act_q[0].cyc - exp_q[0].cyc);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_exponent_round();
    bit ok;
    outReady = 1'b1;
    // block A: +/-1000 -> e=3
    for (int k = 0; k < 12; k++)
      stim.push_back(k == 2 ? mk(1000, 0) : (k == 7 ? mk(-1000, 0) : mk(0, 0)));
    // block B: most negative code plus a 1.5 rounding case at e=8
    for (int k = 0; k < 12; k++)
      stim.push_back(k == 0 ? mk(-32768, 7) : (k == 1 ? mk(384, -384) : mk(rnd_val() >>> 4, rnd_val() >>> 4)));
    drive_stim(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t2_input_stall: got stall, expected 24 accepts"); end
    wait_drain(ok);
    checks++;
    if (!ok || act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t2_count: got %0d outputs expected %0d", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      checks++;
      if (act_q[k].i !== exp_q[k].i || act_q[k].q !== exp_q[k].q || act_q[k].e !== exp_q[k].e ||
          act_q[k].first !== exp_q[k].first || act_q[k].last !== exp_q[k].last) begin
        errors++;
        $display("FAIL t2_sample%0d: got i=%0d q=%0d e=%0d f=%b l=%b expected i=%0d q=%0d e=%0d f=%b l=%b",
                 k, act_q[k].i, act_q[k].q, act_q[k].e, act_q[k].first, act_q[k].last,
                 exp_q[k].i, exp_q[k].q, exp_q[k].e, exp_q[k].first, exp_q[k].last);
      end
    end
    if (act_q.size() == 24) begin
      checks++;
      if (act_q[2].e !== 3 || act_q[2].i !== 125 || act_q[7].i !== -125) begin
        errors++; $display("FAIL t2_e3: got e=%0d i=%0d,%0d expected 3 125,-125", act_q[2].e, act_q[2].i, act_q[7].i);
      end
      checks++;
      if (act_q[12].e !== 8 || act_q[12].i !== -127 || act_q[13].i !== 2 || act_q[13].q !== -1) begin
        errors++; $display("FAIL t2_e8: got e=%0d i=%0d i=%0d q=%0d expected 8 -127 2 -1",
                           act_q[12].e, act_q[12].i, act_q[13].i, act_q[13].q);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_sync();
    bit ok;
    outReady = 1'b1;
    for (int k = 0; k < 5; k++) stim.push_back(mk(rnd_val() >>> 3, rnd_val() >>> 3));
    drive_stim(0, ok);
    inValid = 1'b1;
    inData = mk(300, -300);
    syncTo10ms = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("FAIL sync_edge_ready: got %b expected 0", inReady); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1) begin errors++; $display("FAIL sync_resume_ready: got %b expected 1", inReady); end
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int k = 0; k < 11; k++) stim.push_back(mk(rnd_val(), rnd_val()));
    drive_stim(0, ok);
    syncTo10ms = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL sync_input_stall: got stall, expected accepts"); end
    wait_drain(ok);
    checks++;
    if (!ok || act_q.size() != exp_q.size() || act_q.size() != 17) begin
      errors++; $display("FAIL sync_count: got %0d outputs expected %0d (17)", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      checks++;
      if (act_q[k].i !== exp_q[k].i || act_q[k].q !== exp_q[k].q || act_q[k].e !== exp_q[k].e ||
          act_q[k].first !== exp_q[k].first || act_q[k].last !== exp_q[k].last) begin
        errors++;
        $display("FAIL sync_sample%0d: got i=%0d q=%0d e=%0d f=%b l=%b expected i=%0d q=%0d e=%0d f=%b l=%b",
                 k, act_q[k].i, act_q[k].q, act_q[k].e, act_q[k].first, act_q[k].last,
                 exp_q[k].i, exp_q[k].q, exp_q[k].e, exp_q[k].first, exp_q[k].last);
      end
    end
    if (act_q.size() == 17) begin
      checks++;
      if (act_q[4].last !== 1'b1 || act_q[5].first !== 1'b1 || act_q[5].i !== exp_q[5].i) begin
        errors++; $display("FAIL sync_boundary: got last4=%b first5=%b expected 1 1", act_q[4].last, act_q[5].first);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_pressure();
    bit ok;
    int acc0;
    outReady = 1'b0;
    acc0 = acc_count;
    inValid = 1'b1;
    repeat (30) begin
      inData = mk(rnd_val(), rnd_val());
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    @(negedge clk);
    checks++;
    if (acc_count - acc0 !== 24) begin errors++; $display("FAIL bp_accepts: got %0d expected 24", acc_count - acc0); end
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inready: got %b expected 0", inReady); end
    @(posedge clk); #1;
    outReady = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d outputs expected %0d", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      checks++;
      if (act_q[k].i !== exp_q[k].i || act_q[k].q !== exp_q[k].q || act_q[k].e !== exp_q[k].e ||
          act_q[k].first !== exp_q[k].first || act_q[k].last !== exp_q[k].last) begin
        errors++;
        $display("FAIL bp_sample%0d: got i=%0d q=%0d e=%0d expected i=%0d q=%0d e=%0d",
                 k, act_q[k].i, act_q[k].q, act_q[k].e, exp_q[k].i, exp_q[k].q, exp_q[k].e);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_traffic();
    bit ok;
    for (int k = 0; k < 72; k++) stim.push_back(mk(rnd_val(), rnd_val()));
    rand_rdy = 1'b1;
    drive_stim(25, ok);
    rand_rdy = 1'b0;
    outReady = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_input_stall: got stall, expected accepts"); end
    wait_drain(ok);
    checks++;
    if (!ok || act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d outputs expected %0d", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      checks++;
      if (act_q[k].i !== exp_q[k].i || act_q[k].q !== exp_q[k].q || act_q[k].e !== exp_q[k].e ||
          act_q[k].first !== exp_q[k].first || act_q[k].last !== exp_q[k].last) begin
        errors++;
        $display("FAIL rand_sample%0d: got i=%0d q=%0d e=%0d f=%b l=%b expected i=%0d q=%0d e=%0d f=%b l=%b",
                 k, act_q[k].i, act_q[k].q, act_q[k].e, act_q[k].first, act_q[k].last,
                 exp_q[k].i, exp_q[k].q, exp_q[k].e, exp_q[k].first, exp_q[k].last);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int t;
    outReady = 1'b1;
    for (int k = 0; k < 12; k++) stim.push_back(mk(rnd_val(), rnd_val()));
    drive_stim(0, ok);
    t = 0;
    while (act_q.size() < 3 && t < 100) begin @(posedge clk); #1; t++; end
    checks++;
    if (act_q.size() < 3) begin errors++; $display("FAIL rst_drain_start: got %0d outputs expected >=3", act_q.size()); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("FAIL rst_mid_inready: got %b expected 0", inReady); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || quantizedData !== 16'h0 || blockExponent !== 4'h0 ||
        outFirst !== 1'b0 || outLast !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs: got v=%b d=%h e=%0d f=%b l=%b rdy=%b expected 0 0 0 0 0 1",
               outValid, quantizedData, blockExponent, outFirst, outLast, inReady);
    end
    act_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL rst_no_partial: got %0d outputs expected 0", act_q.size()); end
    for (int k = 0; k < 12; k++) stim.push_back(k == 4 ? mk(-1000, 1000) : mk(17, -3));
    drive_stim(0, ok);
    wait_drain(ok);
    checks++;
    if (!ok || act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_after_count: got %0d outputs expected %0d", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
      checks++;
      if (act_q[k].i !== exp_q[k].i || act_q[k].q !== exp_q[k].q || act_q[k].e !== exp_q[k].e ||
          act_q[k].first !== exp_q[k].first || act_q[k].last !== exp_q[k].last) begin
        errors++;
        $display("FAIL rst_after_sample%0d: got i=%0d q=%0d e=%0d expected i=%0d q=%0d e=%0d",
                 k, act_q[k].i, act_q[k].q, act_q[k].e, exp_q[k].i, exp_q[k].q, exp_q[k].e);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_constant_block();
    test_exponent_round();
    test_frame_sync();
    test_back_pressure();
    test_random_traffic();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_block_quantizer.md
Name: iq_block_quantizer

Overview:
Block-floating-point compressor that sits directly upstream of the rescaler in the fronthaul IQ chain.
- Collects complex input samples into blocks of BLOCK_LEN samples.
- Finds the largest magnitude in each block and derives one shared right-shift exponent.
- Emits each sample requantised to QUANTISATION_BITWIDTH per component, together with the block exponent.
- Blocks are aligned to the 10 ms frame strobe.

Parameters:
INPUT_SAMPLE_BITWIDTH, 16, signed width of each I and Q input component
QUANTISATION_BITWIDTH, 8, signed width of each quantised output component
BLOCK_LEN, 12, samples per block (one LTE resource block)
EXPONENT_BITWIDTH, 4, width of blockExponent; must hold INPUT_SAMPLE_BITWIDTH-QUANTISATION_BITWIDTH

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
syncTo10ms  in  1  frame strobe; the rising edge marks a frame start
inData  in  2*INPUT_SAMPLE_BITWIDTH  I in the upper half, Q in the lower half, two's complement
inValid  in  1  input sample valid
inReady  out  1  input can be accepted; transfer occurs when inValid&&inReady
quantizedData  out  2*QUANTISATION_BITWIDTH  I in the upper half, Q in the lower half
outValid  out  1  output valid
outReady  in  1  downstream accepts; transfer occurs when outValid&&outReady
blockExponent  out  EXPONENT_BITWIDTH  shift applied to the current block
outFirst  out  1  asserted with the first sample of a block
outLast  out  1  asserted with the last sample of a block

Behaviour:
- Reset values: outValid, outFirst, outLast, quantizedData and blockExponent are all 0. inReady is 0 during rst and 1 in the first cycle after rst. Both banks are empty, all counters are 0 and syncTo10ms_d is 0.
- Reset mid-operation discards all buffered samples. No partial output follows.
- Storage: ping-pong, two banks of BLOCK_LEN entries each. Each bank has a state FREE, FILLING, CLOSED or DRAINING.
  - The write pointer alternates between banks.
  - inReady = (write bank is FREE or FILLING) && !syncEdge.
- Accept: each transfer writes the sample at index wrCnt and updates runMax with max(|I|,|Q|).
  - |x| saturates: -2^(IN-1) maps to 2^(IN-1)-1.
  - Accepting the sample at wrCnt==BLOCK_LEN-1 closes the bank with len=BLOCK_LEN. wrCnt and runMax clear and the write bank toggles.
- Frame sync: syncEdge = syncTo10ms && !syncTo10ms_d.
  - In the syncEdge cycle inReady is forced to 0.
  - If wrCnt>0, the partial bank is closed with len=wrCnt. If wrCnt==0, nothing happens.
  - Acceptance resumes in the next cycle.
- Exponent: e = the smallest value in 0..IN-QW with (runMax >> e) < 2^(QW-1).
  - It is computed from the final runMax and registered with the bank one cycle after close (state CLOSED).
- Drain: the read side serves banks in close order, one sample per cycle while outReady=1.
  - Result = (x + (e>0 ? 2^(e-1) : 0)) >>> e, using round-half-up with an arithmetic shift.
  - The result saturates to [-(2^(QW-1)-1), 2^(QW-1)-1], so the output is symmetric and -2^(QW-1) is never emitted.
  - I and Q are processed independently.
- Output stage is registered. While outValid && !outReady, quantizedData, blockExponent, outFirst and outLast hold stable.
- The bank returns to FREE in the cycle its last sample transfers. It may be refilled starting in the next cycle.
- Latency: outValid rises 2 cycles after the closing event (last accepted sample or syncEdge), assuming the read side is idle.
- Throughput: 1 sample per clock sustained with outReady=1.
- Back-pressure: when both banks are CLOSED or DRAINING, inReady=0. No sample is ever dropped or reordered.

Decomposition:
- Add to the shared system_parameters package:
  - INPUT_SAMPLE_BITWIDTH, BLOCK_LEN and EXPONENT_BITWIDTH.
  - typedef iq_in_t (packed I/Q input) and iq_q_t (packed quantised I/Q).
  - typedef bank_state_t {FREE, FILLING, CLOSED, DRAINING}.
- QUANTISATION_BITWIDTH already lives in the package.
- One sub-module, bfp_exponent_calc: combinational runMax to exponent via leading-one detection. Reused by the decompressor side.

Test Plan:
- 12 samples with I=100, Q=-50, outReady=1 -> 12 outputs with I=100, Q=-50, blockExponent=0, outFirst on sample 0, outLast on sample 11, first outValid 2 cycles after the 12th accept.
- Block containing I=1000 and a later sample I=-1000, others 0 -> e=3; outputs I=125 and I=-125.
- Block containing I=-32768 -> e=8; that sample outputs I=-127 (saturated); a sample with I=384 outputs I=2 (rounding 1.5 up).
- syncTo10ms rising after 5 accepted samples -> inReady=0 for exactly that cycle; a 5-sample block is emitted with outLast on the 5th; the next block starts at sample 6 with outFirst.
- Continuous input with outReady=0 for 30 cycles -> inReady falls after 24 accepts; after release, all samples emerge in order and none are lost.
- rst asserted mid-drain -> next cycle outValid=0, all outputs 0, inReady=1; a new block after reset is quantised correctly.
